// File: rtl/branch_ctrl_pkg.sv
// Shared encodings for the branch controller: opcodes, JCC conditions, flag bit
// positions and FSM states.
package branch_ctrl_pkg;

    localparam logic [2:0] OpNop  = 3'd0;
    localparam logic [2:0] OpJmp  = 3'd1;
    localparam logic [2:0] OpJcc  = 3'd2;
    localparam logic [2:0] OpCall = 3'd3;
    localparam logic [2:0] OpRet  = 3'd4;
    localparam logic [2:0] OpHlt  = 3'd5;

    localparam logic [2:0] CondAlways = 3'd0;
    localparam logic [2:0] CondC      = 3'd1;
    localparam logic [2:0] CondNc     = 3'd2;
    localparam logic [2:0] CondZ      = 3'd3;
    localparam logic [2:0] CondNz     = 3'd4;
    localparam logic [2:0] CondS      = 3'd5;
    localparam logic [2:0] CondNs     = 3'd6;
    localparam logic [2:0] CondNever  = 3'd7;

    localparam int unsigned FlagC = 0;
    localparam int unsigned FlagZ = 1;
    localparam int unsigned FlagS = 2;

    typedef enum logic [1:0] {
        StRun   = 2'd0,
        StFlush = 2'd1,
        StHalt  = 2'd2
    } state_e;

endpackage

// File: rtl/branch_ctrl_ret_stack.sv
// Return-address LIFO holding up to DEPTH program counter values.
// Push when full and pop when empty are ignored; the caller flags those cases.
module branch_ctrl_ret_stack #(
    parameter int unsigned AW    = 8,
    parameter int unsigned DEPTH = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          i_push,
    input  logic          i_pop,
    input  logic [AW-1:0] i_push_data,
    output logic [AW-1:0] o_pop_data,
    output logic          o_full,
    output logic          o_empty
);

    localparam int unsigned IW = $clog2(DEPTH);
    localparam int unsigned CW = $clog2(DEPTH + 1);

    logic [AW-1:0] r_mem [DEPTH];
    logic [CW-1:0] r_cnt;
    logic [IW-1:0] w_top_idx;

    // Index arithmetic wraps in IW bits, so a full stack still points at the last entry.
    assign w_top_idx  = r_cnt[IW-1:0] - IW'(1);
    assign o_pop_data = r_mem[w_top_idx];
    assign o_full     = (r_cnt == CW'(DEPTH));
    assign o_empty    = (r_cnt == '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
            for (int i = 0; i < int'(DEPTH); i++) begin
                r_mem[i] <= '0;
            end
        end else if (i_push && !o_full) begin
            r_mem[r_cnt[IW-1:0]] <= i_push_data;
            r_cnt                <= r_cnt + CW'(1);
        end else if (i_pop && !o_empty) begin
            r_cnt <= r_cnt - CW'(1);
        end
    end

endmodule

// File: rtl/branch_ctrl.sv
// Program counter and branch resolution against the registered ALU flags, with a
// return-address stack and a RUN/FLUSH/HALT sequencer.
module branch_ctrl
    import branch_ctrl_pkg::*;
#(
    parameter int unsigned AW    = 8,
    parameter int unsigned DEPTH = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          en,
    input  logic [2:0]    op,
    input  logic [2:0]    cond,
    input  logic [AW-1:0] target,
    input  logic [2:0]    f,
    output logic [AW-1:0] pc,
    output logic          taken,
    output logic          flush,
    output logic          halted,
    output logic          stk_ovf,
    output logic          stk_unf
);

    function automatic logic cond_true(input logic [2:0] c, input logic [2:0] fl);
        logic res;
        case (c)
            CondAlways: res = 1'b1;
            CondC:      res = fl[FlagC];
            CondNc:     res = !fl[FlagC];
            CondZ:      res = fl[FlagZ];
            CondNz:     res = !fl[FlagZ];
            CondS:      res = fl[FlagS];
            CondNs:     res = !fl[FlagS];
            CondNever:  res = 1'b0;
            default:    res = 1'b0;
        endcase
        return res;
    endfunction

    state_e        r_state, w_state_d;
    logic [AW-1:0] r_pc, w_pc_d, w_pc_inc;
    logic          r_taken, w_taken_d;
    logic          r_ovf, w_ovf_d;
    logic          r_unf, w_unf_d;
    logic          w_push, w_pop;
    logic [AW-1:0] w_pop_data;
    logic          w_full, w_empty;

    assign w_pc_inc = r_pc + AW'(1);

    branch_ctrl_ret_stack #(
        .AW    (AW),
        .DEPTH (DEPTH)
    ) u_ret_stack (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_push      (w_push),
        .i_pop       (w_pop),
        .i_push_data (w_pc_inc),
        .o_pop_data  (w_pop_data),
        .o_full      (w_full),
        .o_empty     (w_empty)
    );

    always_comb begin
        w_state_d = r_state;
        w_pc_d    = r_pc;
        w_taken_d = 1'b0;
        w_ovf_d   = r_ovf;
        w_unf_d   = r_unf;
        w_push    = 1'b0;
        w_pop     = 1'b0;
        if (en) begin
            case (r_state)
                StRun: begin
                    case (op)
                        OpJmp: begin
                            w_pc_d    = target;
                            w_taken_d = 1'b1;
                            w_state_d = StFlush;
                        end
                        OpJcc: begin
                            if (cond_true(cond, f)) begin
                                w_pc_d    = target;
                                w_taken_d = 1'b1;
                                w_state_d = StFlush;
                            end else begin
                                w_pc_d = w_pc_inc;
                            end
                        end
                        OpCall: begin
                            if (!w_full) begin
                                w_push    = 1'b1;
                                w_pc_d    = target;
                                w_taken_d = 1'b1;
                                w_state_d = StFlush;
                            end else begin
                                w_ovf_d = 1'b1;
                                w_pc_d  = w_pc_inc;
                            end
                        end
                        OpRet: begin
                            if (!w_empty) begin
                                w_pop     = 1'b1;
                                w_pc_d    = w_pop_data;
                                w_taken_d = 1'b1;
                                w_state_d = StFlush;
                            end else begin
                                w_unf_d = 1'b1;
                                w_pc_d  = w_pc_inc;
                            end
                        end
                        OpHlt:   w_state_d = StHalt;
                        default: w_pc_d = w_pc_inc;
                    endcase
                end
                StFlush: w_state_d = StRun;
                StHalt:  w_state_d = StHalt;
                default: w_state_d = StRun;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= StRun;
            r_pc    <= '0;
            r_taken <= 1'b0;
            r_ovf   <= 1'b0;
            r_unf   <= 1'b0;
        end else begin
            r_state <= w_state_d;
            r_pc    <= w_pc_d;
            r_taken <= w_taken_d;
            r_ovf   <= w_ovf_d;
            r_unf   <= w_unf_d;
        end
    end

    assign pc      = r_pc;
    assign taken   = r_taken;
    assign flush   = (r_state == StFlush);
    assign halted  = (r_state == StHalt);
    assign stk_ovf = r_ovf;
    assign stk_unf = r_unf;

endmodule

// File: tb/tb_branch_ctrl.sv
// Directed-vector bench for branch_ctrl (AW=8, DEPTH=4) with hand-computed expectations.
module tb_branch_ctrl;

    logic       clk;
    logic       rst_n;
    logic       en;
    logic [2:0] op;
    logic [2:0] cond;
    logic [7:0] target;
    logic [2:0] f;
    logic [7:0] pc;
    logic       taken, flush, halted, stk_ovf, stk_unf;

    int n_vec;
    int n_err;

    branch_ctrl #(
        .AW    (8),
        .DEPTH (4)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .en      (en),
        .op      (op),
        .cond    (cond),
        .target  (target),
        .f       (f),
        .pc      (pc),
        .taken   (taken),
        .flush   (flush),
        .halted  (halted),
        .stk_ovf (stk_ovf),
        .stk_unf (stk_unf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL timeout: got no finish, required finish within 200us");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, required %0h", tag, got, exp);
        end
    endtask

    // Inputs change 1ns after an edge and are sampled on the next one.
    task automatic step(input logic [2:0] op_v, input logic [2:0] cond_v,
                        input logic [7:0] tgt_v);
        op     = op_v;
        cond   = cond_v;
        target = tgt_v;
        @(posedge clk);
        #1;
    endtask

    task automatic expect_out(input string tag, input logic [7:0] e_pc, input logic e_taken,
                              input logic e_flush);
        check({tag, ".pc"}, 32'(pc), 32'(e_pc));
        check({tag, ".taken"}, 32'(taken), 32'(e_taken));
        check({tag, ".flush"}, 32'(flush), 32'(e_flush));
    endtask

    task automatic expect_all_zero(input string tag);
        check({tag, ".pc"}, 32'(pc), 32'h0);
        check({tag, ".taken"}, 32'(taken), 32'h0);
        check({tag, ".flush"}, 32'(flush), 32'h0);
        check({tag, ".halted"}, 32'(halted), 32'h0);
        check({tag, ".ovf"}, 32'(stk_ovf), 32'h0);
        check({tag, ".unf"}, 32'(stk_unf), 32'h0);
    endtask

    initial begin
        n_vec  = 0;
        n_err  = 0;
        rst_n  = 1'b0;
        en     = 1'b0;
        op     = 3'd0;
        cond   = 3'd0;
        target = 8'h00;
        f      = 3'b000;
        repeat (2) @(posedge clk);
        #1;
        expect_all_zero("reset");
        rst_n = 1'b1;
        en    = 1'b1;

        // Sequential fetch
        step(3'd0, 3'd0, 8'h00); expect_out("nop1", 8'h01, 1'b0, 1'b0);
        step(3'd0, 3'd0, 8'h00); expect_out("nop2", 8'h02, 1'b0, 1'b0);
        step(3'd0, 3'd0, 8'h00); expect_out("nop3", 8'h03, 1'b0, 1'b0);
        step(3'd6, 3'd0, 8'h99); expect_out("op6", 8'h04, 1'b0, 1'b0);

        // Conditional jumps
        f = 3'b010;
        step(3'd2, 3'd3, 8'h40); expect_out("jz_t", 8'h40, 1'b1, 1'b1);
        step(3'd1, 3'd0, 8'h77); expect_out("jz_fl", 8'h40, 1'b0, 1'b0);
        f = 3'b000;
        step(3'd2, 3'd3, 8'h50); expect_out("jz_nt", 8'h41, 1'b0, 1'b0);
        f = 3'b111;
        step(3'd2, 3'd7, 8'h50); expect_out("jnever", 8'h42, 1'b0, 1'b0);
        step(3'd2, 3'd6, 8'h50); expect_out("jns_nt", 8'h43, 1'b0, 1'b0);
        step(3'd2, 3'd1, 8'h08); expect_out("jc_t", 8'h08, 1'b1, 1'b1);
        step(3'd0, 3'd0, 8'h00); expect_out("jc_fl", 8'h08, 1'b0, 1'b0);
        f = 3'b000;
        step(3'd2, 3'd2, 8'h10); expect_out("jnc_t", 8'h10, 1'b1, 1'b1);
        step(3'd0, 3'd0, 8'h00); expect_out("jnc_fl", 8'h10, 1'b0, 1'b0);

        // Call / return
        step(3'd3, 3'd0, 8'h80); expect_out("call", 8'h80, 1'b1, 1'b1);
        step(3'd0, 3'd0, 8'h00); expect_out("call_fl", 8'h80, 1'b0, 1'b0);
        step(3'd4, 3'd0, 8'h00); expect_out("ret", 8'h11, 1'b1, 1'b1);
        step(3'd0, 3'd0, 8'h00); expect_out("ret_fl", 8'h11, 1'b0, 1'b0);

        // Nest to overflow: pushes 12, A1, B1, C1; fifth call is refused
        step(3'd3, 3'd0, 8'hA0); step(3'd0, 3'd0, 8'h00);
        step(3'd3, 3'd0, 8'hB0); step(3'd0, 3'd0, 8'h00);
        step(3'd3, 3'd0, 8'hC0); step(3'd0, 3'd0, 8'h00);
        step(3'd3, 3'd0, 8'hD0); expect_out("call4", 8'hD0, 1'b1, 1'b1);
        step(3'd0, 3'd0, 8'h00);
        check("ovf_before", 32'(stk_ovf), 32'h0);
        step(3'd3, 3'd0, 8'hE0); expect_out("call5", 8'hD1, 1'b0, 1'b0);
        check("ovf_set", 32'(stk_ovf), 32'h1);

        // Drain in LIFO order, then underflow
        step(3'd4, 3'd0, 8'h00); expect_out("pop1", 8'hC1, 1'b1, 1'b1);
        step(3'd0, 3'd0, 8'h00);
        step(3'd4, 3'd0, 8'h00); expect_out("pop2", 8'hB1, 1'b1, 1'b1);
        step(3'd0, 3'd0, 8'h00);
        step(3'd4, 3'd0, 8'h00); expect_out("pop3", 8'hA1, 1'b1, 1'b1);
        step(3'd0, 3'd0, 8'h00);
        step(3'd4, 3'd0, 8'h00); expect_out("pop4", 8'h12, 1'b1, 1'b1);
        step(3'd0, 3'd0, 8'h00);
        check("unf_before", 32'(stk_unf), 32'h0);
        step(3'd4, 3'd0, 8'h00); expect_out("ret_empty", 8'h13, 1'b0, 1'b0);
        check("unf_set", 32'(stk_unf), 32'h1);
        step(3'd0, 3'd0, 8'h00); expect_out("after_unf", 8'h14, 1'b0, 1'b0);
        check("unf_sticky", 32'(stk_unf), 32'h1);
        check("ovf_sticky", 32'(stk_ovf), 32'h1);

        // en=0 holds in RUN and in FLUSH
        en = 1'b0;
        step(3'd1, 3'd0, 8'h66); expect_out("hold_run", 8'h14, 1'b0, 1'b0);
        en = 1'b1;
        step(3'd1, 3'd0, 8'hFF); expect_out("jmp_ff", 8'hFF, 1'b1, 1'b1);
        en = 1'b0;
        step(3'd0, 3'd0, 8'h00); expect_out("hold_flush", 8'hFF, 1'b0, 1'b1);
        en = 1'b1;
        step(3'd0, 3'd0, 8'h00); expect_out("flush_done", 8'hFF, 1'b0, 1'b0);

        // PC wrap and wrapped return address
        step(3'd0, 3'd0, 8'h00); expect_out("wrap", 8'h00, 1'b0, 1'b0);
        step(3'd1, 3'd0, 8'hFF); step(3'd0, 3'd0, 8'h00);
        step(3'd3, 3'd0, 8'h30); expect_out("call_ff", 8'h30, 1'b1, 1'b1);
        step(3'd0, 3'd0, 8'h00);
        step(3'd4, 3'd0, 8'h00); expect_out("ret_wrap", 8'h00, 1'b1, 1'b1);
        step(3'd0, 3'd0, 8'h00);

        // Halt
        step(3'd5, 3'd0, 8'h00); expect_out("hlt", 8'h00, 1'b0, 1'b0);
        check("halted", 32'(halted), 32'h1);
        step(3'd1, 3'd0, 8'h55); expect_out("hlt_jmp", 8'h00, 1'b0, 1'b0);
        check("halted_hold", 32'(halted), 32'h1);

        // Async reset mid-cycle, then mid-FLUSH
        #2 rst_n = 1'b0;
        #1 expect_all_zero("rst_halt");
        rst_n = 1'b1;
        step(3'd1, 3'd0, 8'h20); expect_out("jmp20", 8'h20, 1'b1, 1'b1);
        #2 rst_n = 1'b0;
        #1 expect_all_zero("rst_flush");
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Stack contents must be gone after reset
        step(3'd3, 3'd0, 8'h60); step(3'd0, 3'd0, 8'h00);
        #2 rst_n = 1'b0;
        #1 rst_n = 1'b1;
        step(3'd4, 3'd0, 8'h00); expect_out("ret_after_rst", 8'h01, 1'b0, 1'b0);
        check("unf_after_rst", 32'(stk_unf), 32'h1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
